issue_scheduler: RTL and testbench

- In-order issue queue with register scoreboard, placed between the decoder and the execute units.
- Buffers decoded instructions (operand-need/address and write-back fields plus an opaque payload) and issues the head entry only when RAW/WAW hazards are clear and the execute side accepts.
- Write-back notifications release scoreboard bits.

---
 rtl/issue_scheduler.sv | 161 ++++++++++++++++
 tb/tb_issue_scheduler.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_scheduler.sv
// In-order issue queue with a 32-entry register scoreboard. The head entry issues
// once its RAW/WAW hazards clear and the execute side accepts it.
module issue_scheduler #(
  parameter int DEPTH     = 4,
  parameter int PTR_W     = 2,
  parameter int PAYLOAD_W = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 enq_valid,
  output logic                 enq_ready,
  input  logic                 enq_num1_need,
  input  logic [4:0]           enq_num1_addr,
  input  logic                 enq_num2_need,
  input  logic [4:0]           enq_num2_addr,
  input  logic                 enq_wr_need,
  input  logic [4:0]           enq_wr_addr,
  input  logic [PAYLOAD_W-1:0] enq_payload,
  output logic                 iss_valid,
  input  logic                 iss_ready,
  output logic [4:0]           iss_num1_addr,
  output logic [4:0]           iss_num2_addr,
  output logic                 iss_wr_need,
  output logic [4:0]           iss_wr_addr,
  output logic [PAYLOAD_W-1:0] iss_payload,
  input  logic                 wb_valid,
  input  logic [4:0]           wb_addr,
  output logic [PTR_W:0]       count,
  output logic [15:0]          stall_cycles
);

  typedef struct packed {
    logic                 num1_need;
    logic [4:0]           num1_addr;
    logic                 num2_need;
    logic [4:0]           num2_addr;
    logic                 wr_need;
    logic [4:0]           wr_addr;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_ZERO = {(PTR_W+1){1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};

  entry_t           mem_r [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [PTR_W:0]   count_r;
  logic [31:0]      busy_r;
  logic [15:0]      stall_r;

  entry_t      head_s;
  logic        not_empty_s;
  logic        blocked_s;
  logic        enq_fire_s;
  logic        iss_fire_s;
  logic [31:0] busy_set_s;
  logic [31:0] busy_clr_s;

  // A same-cycle write-back hides the busy bit; register 0 is never busy.
  function automatic logic eff_busy(input logic [31:0] busy, input logic wbv,
                                    input logic [4:0] wba, input logic [4:0] r);
    return (r != 5'd0) && busy[r] && !(wbv && (wba == r));
  endfunction

  // Hazard evaluation, handshakes and scoreboard update terms.
  always_comb begin
    head_s      = mem_r[head_r];
    not_empty_s = (count_r != CNT_ZERO);
    blocked_s   = (head_s.num1_need && eff_busy(busy_r, wb_valid, wb_addr, head_s.num1_addr)) ||
                  (head_s.num2_need && eff_busy(busy_r, wb_valid, wb_addr, head_s.num2_addr)) ||
                  (head_s.wr_need   && eff_busy(busy_r, wb_valid, wb_addr, head_s.wr_addr));
    enq_ready   = (count_r != CNT_FULL);
    iss_valid   = not_empty_s && !blocked_s;
    enq_fire_s  = enq_valid && enq_ready && !flush;
    iss_fire_s  = iss_valid && iss_ready && !flush;
    if (wb_valid && (wb_addr != 5'd0)) begin
      busy_clr_s = 32'd1 << wb_addr;
    end else begin
      busy_clr_s = 32'd0;
    end
    if (iss_fire_s && head_s.wr_need && (head_s.wr_addr != 5'd0)) begin
      busy_set_s = 32'd1 << head_s.wr_addr;
    end else begin
      busy_set_s = 32'd0;
    end
  end

  // Head entry presentation, held at zero while the queue is empty.
  always_comb begin
    if (not_empty_s) begin
      iss_num1_addr = head_s.num1_addr;
      iss_num2_addr = head_s.num2_addr;
      iss_wr_need   = head_s.wr_need;
      iss_wr_addr   = head_s.wr_addr;
      iss_payload   = head_s.payload;
    end else begin
      iss_num1_addr = 5'd0;
      iss_num2_addr = 5'd0;
      iss_wr_need   = 1'b0;
      iss_wr_addr   = 5'd0;
      iss_payload   = {PAYLOAD_W{1'b0}};
    end
  end

  // Entry storage written at the tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {$bits(entry_t){1'b0}};
      end
    end else if (enq_fire_s) begin
      mem_r[tail_r] <= '{num1_need: enq_num1_need, num1_addr: enq_num1_addr,
                         num2_need: enq_num2_need, num2_addr: enq_num2_addr,
                         wr_need: enq_wr_need, wr_addr: enq_wr_addr,
                         payload: enq_payload};
    end
  end

  // Pointers and occupancy; flush empties the queue but leaves the scoreboard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r  <= PTR_ZERO;
      tail_r  <= PTR_ZERO;
      count_r <= CNT_ZERO;
    end else if (flush) begin
      head_r  <= PTR_ZERO;
      tail_r  <= PTR_ZERO;
      count_r <= CNT_ZERO;
    end else begin
      if (enq_fire_s) tail_r <= tail_r + PTR_ONE;
      if (iss_fire_s) head_r <= head_r + PTR_ONE;
      case ({enq_fire_s, iss_fire_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Scoreboard (set wins over clear) and saturating hazard-stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r  <= 32'd0;
      stall_r <= 16'd0;
    end else begin
      busy_r <= (busy_r & ~busy_clr_s) | busy_set_s;
      if (not_empty_s && blocked_s && (stall_r != 16'hFFFF)) begin
        stall_r <= stall_r + 16'd1;
      end
    end
  end

  assign count        = count_r;
  assign stall_cycles = stall_r;

endmodule

// File: tb/tb_issue_scheduler.sv
// Bench for issue_scheduler: directed vector table, hand sequences for full/wrap/flush,
// then randomized traffic checked every cycle against a queue-based reference model.
module tb_issue_scheduler;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;
  localparam int PW    = 128;

  logic clk, rst_n, flush, enq_valid, enq_ready;
  logic enq_num1_need, enq_num2_need, enq_wr_need;
  logic [4:0] enq_num1_addr, enq_num2_addr, enq_wr_addr;
  logic [PW-1:0] enq_payload, iss_payload;
  logic iss_valid, iss_ready, iss_wr_need, wb_valid;
  logic [4:0] iss_num1_addr, iss_num2_addr, iss_wr_addr, wb_addr;
  logic [PTR_W:0] count;
  logic [15:0] stall_cycles;

  issue_scheduler #(.DEPTH(DEPTH), .PTR_W(PTR_W), .PAYLOAD_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_num1_need(enq_num1_need), .enq_num1_addr(enq_num1_addr),
    .enq_num2_need(enq_num2_need), .enq_num2_addr(enq_num2_addr),
    .enq_wr_need(enq_wr_need), .enq_wr_addr(enq_wr_addr), .enq_payload(enq_payload),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_num1_addr(iss_num1_addr),
    .iss_num2_addr(iss_num2_addr), .iss_wr_need(iss_wr_need), .iss_wr_addr(iss_wr_addr),
    .iss_payload(iss_payload), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .count(count), .stall_cycles(stall_cycles));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit n1n; bit [4:0] n1a; bit n2n; bit [4:0] n2a; bit wn; bit [4:0] wa; bit [PW-1:0] pay;
  } ent_t;
  ent_t mq[$];
  bit   mbusy[32];
  int   mstall;

  function automatic bit m_busy(input bit [4:0] r);
    return (r != 0) && mbusy[r] && !(wb_valid && wb_addr == r);
  endfunction

  function automatic bit m_blocked();
    if (mq.size() == 0) return 1'b0;
    return (mq[0].n1n && m_busy(mq[0].n1a)) || (mq[0].n2n && m_busy(mq[0].n2a)) ||
           (mq[0].wn && m_busy(mq[0].wa));
  endfunction

  task automatic m_reset();
    mq.delete();
    foreach (mbusy[i]) mbusy[i] = 1'b0;
    mstall = 0;
  endtask

  task automatic check_model();
    bit ev;
    ev = (mq.size() != 0) && !m_blocked();
    chk("m_iss_valid", iss_valid, ev);
    chk("m_enq_ready", enq_ready, mq.size() < DEPTH);
    chk("m_count", count, mq.size());
    chk("m_stall", stall_cycles, mstall);
    if (mq.size() != 0) begin
      chk("m_num1", iss_num1_addr, mq[0].n1a);
      chk("m_num2", iss_num2_addr, mq[0].n2a);
      chk("m_wr", {iss_wr_need, iss_wr_addr}, {mq[0].wn, mq[0].wa});
      chk("m_payload", iss_payload, mq[0].pay);
    end else begin
      chk("m_empty_out", {iss_num1_addr, iss_num2_addr, iss_wr_need, iss_wr_addr, iss_payload}, 0);
    end
  endtask

  // Applies the rules to the values present at the clock edge.
  task automatic m_update();
    bit do_iss, do_enq;
    ent_t e;
    do_iss = (mq.size() != 0) && !m_blocked() && iss_ready && !flush;
    do_enq = enq_valid && (mq.size() < DEPTH) && !flush;
    if (mq.size() != 0 && m_blocked() && mstall < 65535) mstall++;
    if (wb_valid && wb_addr != 0) mbusy[wb_addr] = 1'b0;
    if (do_iss && mq[0].wn && mq[0].wa != 0) mbusy[mq[0].wa] = 1'b1;
    if (flush) mq.delete();
    else begin
      if (do_iss) void'(mq.pop_front());
      if (do_enq) begin
        e = '{enq_num1_need, enq_num1_addr, enq_num2_need, enq_num2_addr,
              enq_wr_need, enq_wr_addr, enq_payload};
        mq.push_back(e);
      end
    end
  endtask

  task automatic finish_cycle();
    check_model();
    @(posedge clk);
    m_update();
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    finish_cycle();
  endtask

  task automatic idle();
    flush = 0; enq_valid = 0; enq_num1_need = 0; enq_num1_addr = 0; enq_num2_need = 0;
    enq_num2_addr = 0; enq_wr_need = 0; enq_wr_addr = 0; enq_payload = 0;
    iss_ready = 0; wb_valid = 0; wb_addr = 0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic ev, n1n; logic [4:0] n1a; logic n2n; logic [4:0] n2a; logic wn; logic [4:0] wa;
    logic ir, wbv; logic [4:0] wba;
    logic e_iv; int e_cnt; logic e_er; logic [4:0] e_wa; int e_stall;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input logic ev, n1n, input logic [4:0] n1a, input logic n2n,
      input logic [4:0] n2a, input logic wn, input logic [4:0] wa, input logic ir, wbv,
      input logic [4:0] wba, input logic e_iv, input int e_cnt, input logic e_er,
      input logic [4:0] e_wa, input int e_stall);
    vec_t v;
    v = '{ev, n1n, n1a, n2n, n2a, wn, wa, ir, wbv, wba, e_iv, e_cnt, e_er, e_wa, e_stall};
    return v;
  endfunction

  logic [PW-1:0] got[$];

  initial begin
    idle();
    m_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_enq_ready", enq_ready, 1);
    chk("rst_iss_valid", iss_valid, 0);
    chk("rst_stall", stall_cycles, 0);
    chk("rst_outputs", {iss_num1_addr, iss_num2_addr, iss_wr_need, iss_wr_addr, iss_payload}, 0);
    rst_n = 1;

    // ev n1n n1a n2n n2a wn wa ir wbv wba | iv cnt er wa stall
    tbl.push_back(mk(1,0,0,0,0,1,1,0,0,0, 0,0,1,0,0));   // fill r1..r4 with issue held
    tbl.push_back(mk(1,0,0,0,0,1,2,0,0,0, 1,1,1,1,0));
    tbl.push_back(mk(1,0,0,0,0,1,3,0,0,0, 1,2,1,1,0));
    tbl.push_back(mk(1,0,0,0,0,1,4,0,0,0, 1,3,1,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 1,4,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0, 1,4,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0, 1,3,1,2,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0, 1,2,1,3,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0, 1,1,1,4,0));
    tbl.push_back(mk(1,0,0,0,0,1,5,1,0,0, 0,0,1,0,0));   // RAW on r5
    tbl.push_back(mk(1,1,5,0,0,0,0,1,0,0, 1,1,1,5,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0, 0,1,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0, 0,1,1,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1,5, 1,1,1,0,2));
    tbl.push_back(mk(1,0,0,0,0,1,7,1,0,0, 0,0,1,0,2));   // WAW on r7
    tbl.push_back(mk(1,0,0,0,0,1,7,1,0,0, 1,1,1,7,2));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0, 0,1,1,7,2));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1,7, 1,1,1,7,3));
    tbl.push_back(mk(1,1,7,0,0,0,0,1,0,0, 0,0,1,0,3));   // r7 busy again after set-wins
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0, 0,1,1,0,3));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1,7, 1,1,1,0,4));
    tbl.push_back(mk(1,1,0,1,0,1,0,1,0,0, 0,0,1,0,4));   // register 0
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1,0, 1,1,1,0,4));
    tbl.push_back(mk(1,1,0,1,0,1,0,0,0,0, 0,0,1,0,4));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 1,1,1,0,4));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0, 1,1,1,0,4));
    tbl.push_back(mk(1,1,1,0,0,0,0,1,0,0, 0,0,1,0,4));   // r1 still busy; wb r0 no effect
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1,0, 0,1,1,0,4));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1,1, 1,1,1,0,5));

    foreach (tbl[i]) begin
      enq_valid = tbl[i].ev; enq_num1_need = tbl[i].n1n; enq_num1_addr = tbl[i].n1a;
      enq_num2_need = tbl[i].n2n; enq_num2_addr = tbl[i].n2a; enq_wr_need = tbl[i].wn;
      enq_wr_addr = tbl[i].wa; enq_payload = PW'(i); iss_ready = tbl[i].ir;
      wb_valid = tbl[i].wbv; wb_addr = tbl[i].wba;
      @(negedge clk);
      chk($sformatf("t%0d_iss_valid", i), iss_valid, tbl[i].e_iv);
      chk($sformatf("t%0d_count", i), count, tbl[i].e_cnt);
      chk($sformatf("t%0d_enq_ready", i), enq_ready, tbl[i].e_er);
      chk($sformatf("t%0d_wr_addr", i), iss_wr_addr, tbl[i].e_wa);
      chk($sformatf("t%0d_stall", i), stall_cycles, tbl[i].e_stall);
      finish_cycle();
    end
    idle();

    // Full queue: no pass-through even while the head issues.
    for (int i = 0; i < 4; i++) begin
      enq_valid = 1; enq_payload = PW'(32'hA0 + i);
      step();
    end
    iss_ready = 1; enq_payload = PW'(32'h55);
    @(negedge clk);
    chk("full_enq_ready", enq_ready, 0);
    chk("full_count", count, 4);
    finish_cycle();
    enq_valid = 0;
    @(negedge clk);
    chk("after_full_count", count, 3);
    chk("after_full_enq_ready", enq_ready, 1);
    finish_cycle();
    repeat (4) step();

    // Ten back-to-back entries exercise pointer wrap.
    for (int i = 0; i < 13; i++) begin
      enq_valid = (i < 10); enq_payload = PW'(32'h100 + i);
      @(negedge clk);
      if (iss_valid && iss_ready) got.push_back(iss_payload);
      finish_cycle();
    end
    enq_valid = 0;
    chk("wrap_issued", got.size(), 10);
    foreach (got[i]) chk($sformatf("wrap_pay%0d", i), got[i], PW'(32'h100 + i));

    // Flush with three entries queued and r9 busy.
    iss_ready = 0; enq_valid = 1; enq_wr_need = 1; enq_wr_addr = 9;
    step();
    enq_valid = 0; iss_ready = 1;
    step();
    iss_ready = 0; enq_valid = 1; enq_wr_need = 0; enq_wr_addr = 0;
    repeat (3) step();
    chk("pre_flush_count", count, 3);
    flush = 1; iss_ready = 1;
    step();
    flush = 0; enq_valid = 0;
    @(negedge clk);
    chk("flush_count", count, 0);
    chk("flush_iss_valid", iss_valid, 0);
    finish_cycle();
    enq_valid = 1; enq_num1_need = 1; enq_num1_addr = 9;
    step();
    enq_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("flush_r9_blocked", iss_valid, 0);
      finish_cycle();
    end
    wb_valid = 1; wb_addr = 9;
    @(negedge clk);
    chk("flush_r9_wakeup", iss_valid, 1);
    finish_cycle();
    idle();
    step();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      enq_valid = ($urandom_range(0, 99) < 60);
      enq_num1_need = $urandom_range(0, 1); enq_num1_addr = 5'($urandom_range(0, 7));
      enq_num2_need = $urandom_range(0, 1); enq_num2_addr = 5'($urandom_range(0, 7));
      enq_wr_need = $urandom_range(0, 1);   enq_wr_addr = 5'($urandom_range(0, 7));
      enq_payload = {$urandom, $urandom, $urandom, $urandom};
      iss_ready = ($urandom_range(0, 99) < 70);
      wb_valid = ($urandom_range(0, 99) < 35); wb_addr = 5'($urandom_range(0, 7));
      flush = ($urandom_range(0, 63) == 0);
      step();
    end

    // Asynchronous reset in the middle of traffic.
    idle();
    enq_valid = 1; enq_wr_need = 1; enq_wr_addr = 3;
    repeat (2) step();
    rst_n = 0;
    #2;
    chk("midrst_count", count, 0);
    chk("midrst_iss_valid", iss_valid, 0);
    chk("midrst_enq_ready", enq_ready, 1);
    m_reset();
    idle();
    @(posedge clk); #1;
    rst_n = 1;
    enq_valid = 1; enq_num1_need = 1; enq_num1_addr = 3;
    step();
    enq_valid = 0;
    @(negedge clk);
    chk("midrst_busy_cleared", iss_valid, 1);
    finish_cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
